mem_access_unit: RTL

Load/store initiator between the core pipeline and the word-wide synchronous data memory. Accepts one byte, halfword or word request at a time from the core, drives the memory's read and write ports, extracts and sign/zero-extends sub-word load data, and performs read-modify-write for sub-word stores because the memory only writes whole words. It is the requesting end of the memory's `rdEna/rdAddr/rdData/wrEna/wrAddr/wrData` port set.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator between the core and a word-wide synchronous data memory.
// Optional misaligned-access trap: define MAU_MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reqValid,
    output logic         reqReady,
    input  logic         reqWrite,
    input  logic [1:0]   reqSize,
    input  logic         reqUnsigned,
    input  logic [N-1:0] reqAddr,
    input  logic [N-1:0] reqWData,
    output logic         rspValid,
    input  logic         rspReady,
    output logic [N-1:0] rspData,
    output logic         rspErr,
    output logic         rdEna,
    output logic [N-1:0] rdAddr,
    input  logic [N-1:0] rdData,
    output logic         wrEna,
    output logic [N-1:0] wrAddr,
    output logic [N-1:0] wrData,
    output logic [2:0]   state_dbg
);

    // Handshakes: a request transfers on an edge with reqValid && reqReady; a
    // response transfers on an edge with rspValid && rspReady. rspValid, rspData
    // and rspErr stay stable from assertion until that transfer.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        LATCH     = 3'd2,
        WRITE     = 3'd3,
        RMW_RD    = 3'd4,
        RMW_MERGE = 3'd5,
        RMW_WR    = 3'd6,
        RESP      = 3'd7
    } state_t;

    state_t      state;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [1:0]  req_lo;
    logic [15:0] req_wdata;
    logic        misaligned;

    assign reqReady  = (state == IDLE);
    assign state_dbg = state;

`ifdef MAU_MISALIGN_TRAP_EN
    assign misaligned = ((reqSize == 2'b01) && reqAddr[0]) ||
                        (reqSize[1] && (reqAddr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Byte lane k sits at bits [8k+7:8k]; halfword lane chosen by addr[1].
    function automatic logic [N-1:0] extract(input logic [N-1:0] word,
                                             input logic [1:0]   size,
                                             input logic         uns,
                                             input logic [1:0]   lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extract = uns ? {{(N-8){1'b0}}, b}  : {{(N-8){b[7]}}, b};
            2'b01:   extract = uns ? {{(N-16){1'b0}}, h} : {{(N-16){h[15]}}, h};
            default: extract = word;
        endcase
    endfunction

    function automatic logic [N-1:0] merge(input logic [N-1:0] word,
                                           input logic [15:0]  wdata,
                                           input logic [1:0]   size,
                                           input logic [1:0]   lo);
        merge = word;
        if (size == 2'b00) merge[{lo, 3'b000} +: 8]     = wdata[7:0];
        else               merge[{lo[1], 4'b0000} +: 16] = wdata;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_size  <= 2'b00;
            req_uns   <= 1'b0;
            req_lo    <= 2'b00;
            req_wdata <= '0;
            rspValid  <= 1'b0;
            rspData   <= '0;
            rspErr    <= 1'b0;
            rdEna     <= 1'b0;
            rdAddr    <= '0;
            wrEna     <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid && reqReady) begin
                        req_size  <= reqSize;
                        req_uns   <= reqUnsigned;
                        req_lo    <= reqAddr[1:0];
                        req_wdata <= reqWData[15:0];
                        rdAddr    <= {reqAddr[N-1:2], 2'b00};
                        wrAddr    <= {reqAddr[N-1:2], 2'b00};
                        if (misaligned) begin
                            rspValid <= 1'b1;
                            rspErr   <= 1'b1;
                            rspData  <= '0;
                            state    <= RESP;
                        end else if (!reqWrite) begin
                            rdEna <= 1'b1;
                            state <= READ;
                        end else if (reqSize[1]) begin
                            wrEna  <= 1'b1;
                            wrData <= reqWData;
                            state  <= WRITE;
                        end else begin
                            rdEna <= 1'b1;
                            state <= RMW_RD;
                        end
                    end
                end
                READ: begin
                    rdEna <= 1'b0;
                    state <= LATCH;
                end
                LATCH: begin
                    rspData  <= extract(rdData, req_size, req_uns, req_lo);
                    rspErr   <= 1'b0;
                    rspValid <= 1'b1;
                    state    <= RESP;
                end
                WRITE: begin
                    wrEna    <= 1'b0;
                    rspData  <= '0;
                    rspErr   <= 1'b0;
                    rspValid <= 1'b1;
                    state    <= RESP;
                end
                RMW_RD: begin
                    rdEna <= 1'b0;
                    state <= RMW_MERGE;
                end
                RMW_MERGE: begin
                    wrData <= merge(rdData, req_wdata, req_size, req_lo);
                    wrEna  <= 1'b1;
                    state  <= RMW_WR;
                end
                RMW_WR: begin
                    wrEna    <= 1'b0;
                    rspData  <= '0;
                    rspErr   <= 1'b0;
                    rspValid <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
